// File: rtl/regfile.sv
// General-purpose register file: 32x32 storage, register 0 reads as zero,
// two combinational read ports with same-cycle writeback bypass, and a
// counter of committed writes to registers 1..NUM_REGS-1.
module regfile #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32,
  parameter int CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2,
  output logic [CNT_W-1:0]  wr_count
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic              commit_s;
  logic [DATA_W-1:0] rdata1_s;
  logic [DATA_W-1:0] rdata2_s;

  // Resolve one read port: reset, disable and r0 force zero; a matching
  // writeback in the same cycle wins over storage.
  function automatic logic [DATA_W-1:0] read_port(
    input logic              rst_i,
    input logic              ren,
    input logic [ADDR_W-1:0] raddr,
    input logic              we_i,
    input logic [ADDR_W-1:0] waddr_i,
    input logic [DATA_W-1:0] wdata_i,
    input logic [DATA_W-1:0] stored
  );
    logic [DATA_W-1:0] res;
    if (rst_i) begin
      res = '0;
    end else if (!ren) begin
      res = '0;
    end else if (raddr == '0) begin
      res = '0;
    end else if (we_i && (waddr_i == raddr)) begin
      res = wdata_i;
    end else begin
      res = stored;
    end
    return res;
  endfunction

  // Next storage and counter state for a committed writeback.
  always_comb begin
    regs_d   = regs_q;
    cnt_d    = cnt_q;
    commit_s = we && (waddr != '0);
    if (commit_s) begin
      regs_d[waddr] = wdata;
      cnt_d         = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
    regs_d[0] = '0;
  end

  // Storage and counter flops; synchronous reset drops any write at that edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q <= '{default: '0};
      cnt_q  <= '0;
    end else begin
      regs_q <= regs_d;
      cnt_q  <= cnt_d;
    end
  end

  // Combinational read ports with writeback bypass.
  always_comb begin
    rdata1_s = read_port(rst, re1, raddr1, we, waddr, wdata, regs_q[raddr1]);
    rdata2_s = read_port(rst, re2, raddr2, we, waddr, wdata, regs_q[raddr2]);
  end

  assign rdata1   = rdata1_s;
  assign rdata2   = rdata2_s;
  assign wr_count = cnt_q;

endmodule

// File: doc/regfile.md
Name: regfile

Overview:
- General-purpose register file: 32 entries of 32 bits.
- Sinks the writeback stream from the MEM/WB pipeline register, i.e. the reg_we_o, reg_waddr_o and reg_wdata_o outputs.
- Serves two read ports to the decode stage.
- Write-through bypass lets decode see a value in the same cycle that writeback commits it.
- Register 0 is hardwired to zero.
- A committed-write counter is included for performance/debug.

Parameters:
- DATA_W, 32, register width; matches RegBus.
- ADDR_W, 5, register address width; matches RegAddrBus.
- NUM_REGS, 32, number of registers; must equal 2**ADDR_W.
- CNT_W, 32, width of the committed-write counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high (RstEnable = 1).
- we  in  1  writeback write enable, from MEM/WB reg_we_o.
- waddr  in  ADDR_W  writeback register address, from MEM/WB reg_waddr_o.
- wdata  in  DATA_W  writeback data, from MEM/WB reg_wdata_o.
- re1  in  1  read port 1 enable.
- raddr1  in  ADDR_W  read port 1 address.
- rdata1  out  DATA_W  read port 1 data (combinational).
- re2  in  1  read port 2 enable.
- raddr2  in  ADDR_W  read port 2 address.
- rdata2  out  DATA_W  read port 2 data (combinational).
- wr_count  out  CNT_W  number of committed writes to registers 1..31 since reset.

Behaviour:
- Storage: regs[0..NUM_REGS-1], DATA_W each.

Reset (rst=1 at a rising edge):
- All regs cleared to 0.
- wr_count cleared to 0.
- Any write presented in that cycle is dropped and not counted.
- While rst=1, rdata1 and rdata2 are 0 regardless of enables; no bypass.

Write:
- At a rising edge with rst=0, we=1 and waddr!=0: regs[waddr] <= wdata.
- Same condition: wr_count <= wr_count+1. It wraps modulo 2**CNT_W; no saturation.
- we=1 with waddr=0: no storage change and no count.
- Write latency is one cycle: the value is in storage from the next cycle.

Read, port n (identical logic for ports 1 and 2), evaluated in priority order:
1. rst=1 -> 0.
2. ren=0 -> 0.
3. raddrn=0 -> 0, even if we=1 and waddr=0 with nonzero wdata.
4. we=1 and waddr==raddrn -> wdata (same-cycle bypass).
5. Otherwise -> regs[raddrn].

Read-port properties:
- Reads are combinational: zero-cycle latency from address/enable to data.
- Both ports may read the same address simultaneously; each resolves independently.
- A bypassed value and the committed storage value are identical from the following cycle onward.
- No read has side effects.

Boundary conditions:
- Back-to-back writes to the same address: the last write wins. Each write counts separately.
- X/undefined waddr while we=0 has no effect.
- Reset asserted mid-stream: the pending write at that edge is discarded. The first write after reset deassertion is counted as 1.

Timing:
- Read ports are a combinational path from the writeback inputs (bypass mux) into decode.
- Writes are the only sequential path.

Test Plan:
1. Reset then reads:
   - Stimulus: rst=1 for 2 cycles; then re1=re2=1, raddr1=5, raddr2=31.
   - Required: rdata1=0, rdata2=0, wr_count=0.
   - Also: during reset with we=1, waddr=3, wdata=0xDEADBEEF, rdata1 (raddr1=3, re1=1) = 0.
2. Basic write/read and latency:
   - Stimulus: we=1, waddr=7, wdata=0x12345678 for one edge, then we=0; next cycle re1=1, raddr1=7.
   - Required: rdata1=0x12345678, wr_count=1.
   - With re1=0, raddr1=7: rdata1=0.
3. Same-cycle bypass on both ports:
   - Stimulus: regs[9]=0x11111111; then we=1, waddr=9, wdata=0xA5A5A5A5 with re1=re2=1, raddr1=raddr2=9.
   - Required: rdata1=rdata2=0xA5A5A5A5 in that cycle, and storage holds 0xA5A5A5A5 after the edge.
   - With raddr2=10 in the same cycle: rdata2=regs[10].
4. Register 0 protection:
   - Stimulus: we=1, waddr=0, wdata=0xFFFFFFFF; re1=1, raddr1=0, in the same cycle and the next.
   - Required: rdata1=0 both cycles, wr_count unchanged.
5. Counter and last-write-wins:
   - Stimulus: writes to r4 of 1, 2, 3 on consecutive edges, then a write to r0.
   - Required: rdata(4)=3 and wr_count=3.
   - Counter wrap: with CNT_W=4, 17 writes -> wr_count=1.
6. Reset mid-operation:
   - Stimulus: after r12=0x55, assert rst for one edge while we=1, waddr=12, wdata=0x66; deassert; read r12; then one write to r1.
   - Required: rdata(12)=0, then wr_count=1 after the r1 write.
